// File: rtl/path_playback.sv
// Reader end of the path memory: replays {direction, count} run-length entries,
// holding each direction for count Ticks, until a terminator, the last address or Abort.
module path_playback #(
    parameter int ADDR_WIDTH  = 10,
    parameter int COUNT_WIDTH = 14
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   tick,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    input  logic [COUNT_WIDTH+2:0] mem_data,
    output logic [2:0]             direction,
    output logic                   busy,
    output logic                   done
);

    localparam logic [2:0] DIR_NONE = 3'd0;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] PLAY  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = '1;
    localparam logic [COUNT_WIDTH-1:0] ONE       = COUNT_WIDTH'(1);

    typedef struct packed {
        logic [2:0]             dir;
        logic [COUNT_WIDTH-1:0] count;
    } entry_t;

    entry_t                 entry;
    logic [2:0]             state;
    logic [COUNT_WIDTH-1:0] remaining;
    logic                   tick_pending;
    logic                   tick_eff;
    logic                   at_last;

    assign entry    = entry_t'(mem_data);
    assign at_last  = (mem_address == LAST_ADDR);
    assign tick_eff = tick | tick_pending;
    assign busy     = (state == FETCH) || (state == LOAD) || (state == PLAY);
    assign done     = (state == DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            mem_address  <= '0;
            direction    <= DIR_NONE;
            remaining    <= '0;
            tick_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    direction <= DIR_NONE;
                    if (start) begin
                        mem_address  <= '0;
                        tick_pending <= 1'b0;
                        state        <= FETCH;
                    end
                end
                FETCH: begin
                    if (abort) begin
                        state <= DONE;
                    end else begin
                        // a Tick while the next entry is in flight is owed to that entry
                        tick_pending <= tick_pending | tick;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= DONE;
                    end else begin
                        tick_pending <= tick_pending | tick;
                        if (entry.count == '0) begin
                            // zero-length entry: terminator when None, otherwise skipped
                            if (entry.dir == DIR_NONE || at_last) begin
                                state <= DONE;
                            end else begin
                                mem_address <= mem_address + 1'b1;
                                state       <= FETCH;
                            end
                        end else begin
                            direction <= entry.dir;
                            remaining <= entry.count;
                            state     <= PLAY;
                        end
                    end
                end
                PLAY: begin
                    if (abort) begin
                        state <= DONE;
                    end else if (tick_eff) begin
                        tick_pending <= 1'b0;
                        remaining    <= remaining - 1'b1;
                        if (remaining == ONE) begin
                            if (at_last) begin
                                state <= DONE;
                            end else begin
                                mem_address <= mem_address + 1'b1;
                                state       <= FETCH;
                            end
                        end
                    end
                end
                DONE: begin
                    direction    <= DIR_NONE;
                    tick_pending <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_path_playback.sv
// Directed bench for path_playback: two instances (full-size and 4-entry memory) fed by
// synchronous RAM models; each run logs direction/address changes and the Done cycle.
module tb_path_playback;

    localparam logic [2:0] NONE  = 3'd0;
    localparam logic [2:0] FWD   = 3'd1;
    localparam logic [2:0] BACK  = 3'd2;
    localparam logic [2:0] LEFT  = 3'd3;
    localparam logic [2:0] RIGHT = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0, start2 = 1'b0, abort = 1'b0, tick = 1'b0;
    logic [9:0]  mem_address1;
    logic [1:0]  mem_address2;
    logic [16:0] mem_data1 = '0, mem_data2 = '0;
    logic [2:0]  direction1, direction2;
    logic        busy1, busy2, done1, done2;

    logic [16:0] ram1 [0:1023];
    logic [16:0] ram2 [0:3];

    int          checks = 0;
    int          errors = 0;

    int          done_cyc, issued, dir_n, addr_n;
    logic [31:0] dir_code, addr_code;
    int          tally [8];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_data1 <= ram1[mem_address1];
        mem_data2 <= ram2[mem_address2];
    end

    path_playback #(.ADDR_WIDTH(10), .COUNT_WIDTH(14)) dut1 (
        .clock(clk), .reset(rst), .start(start1), .abort(abort), .tick(tick),
        .mem_address(mem_address1), .mem_data(mem_data1),
        .direction(direction1), .busy(busy1), .done(done1)
    );

    path_playback #(.ADDR_WIDTH(2), .COUNT_WIDTH(14)) dut2 (
        .clock(clk), .reset(rst), .start(start2), .abort(abort), .tick(tick),
        .mem_address(mem_address2), .mem_data(mem_data2),
        .direction(direction2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [16:0] ent(input logic [2:0] d, input int n);
        return {d, 14'(n)};
    endfunction

    task automatic clear_ram;
        for (int i = 0; i < 1024; i++) ram1[i] = '0;
        for (int i = 0; i < 4; i++) ram2[i] = '0;
    endtask

    // Runs one playback: Start at cycle 0, nt Ticks every per cycles from cycle ph,
    // optional Abort / extra Start cycles; stops when Done is seen or after max_cyc cycles.
    task automatic play(input bit sel, input int nt, input int ph, input int per,
                        input int abort_cyc, input int restart_cyc, input int max_cyc);
        logic [2:0] d, last_d;
        logic [9:0] a, last_a;
        done_cyc = -1; issued = 0; dir_n = 0; addr_n = 0;
        dir_code = '0; addr_code = '0;
        foreach (tally[i]) tally[i] = 0;
        last_d = NONE;
        last_a = '1;
        for (int cyc = 0; cyc < max_cyc && done_cyc < 0; cyc++) begin
            @(negedge clk);
            d = sel ? direction2 : direction1;
            a = sel ? {8'd0, mem_address2} : mem_address1;
            if (d != last_d) begin
                dir_code = (dir_code << 3) | 32'(d);
                dir_n++;
                last_d = d;
            end
            if (cyc > 0 && (addr_n == 0 || a != last_a)) begin
                addr_code = (addr_code << 4) | 32'(a[3:0]);
                addr_n++;
                last_a = a;
            end
            if (sel ? done2 : done1) done_cyc = cyc;
            start1 = !sel && (cyc == 0 || cyc == restart_cyc);
            start2 = sel && (cyc == 0);
            abort  = (cyc == abort_cyc);
            tick   = (issued < nt) && (cyc >= ph) && ((cyc - ph) % per == 0);
            if (tick) begin
                issued++;
                tally[d]++;
            end
        end
        start1 = 1'b0; start2 = 1'b0; abort = 1'b0; tick = 1'b0;
    endtask

    task automatic idle_chk(input string tag, input bit sel);
        @(negedge clk);
        chk({tag, "_done"}, sel ? done2 : done1, 0);
        chk({tag, "_busy"}, sel ? busy2 : busy1, 0);
        chk({tag, "_dir"},  sel ? direction2 : direction1, NONE);
    endtask

    initial begin
        clear_ram();
        repeat (3) @(negedge clk);
        chk("rst_addr", mem_address1, 0);
        chk("rst_dir",  direction1, NONE);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: Fwd 3, Left 2, terminator; Tick every 4 clocks starting in PLAY
        clear_ram();
        ram1[0] = ent(FWD, 3); ram1[1] = ent(LEFT, 2);
        play(0, 5, 3, 4, -1, -1, 200);
        chk("t1_done_cyc", done_cyc, 22);
        chk("t1_fwd_ticks", tally[FWD], 3);
        chk("t1_left_ticks", tally[LEFT], 2);
        chk("t1_dir_seq", dir_code, {FWD, LEFT});
        chk("t1_dir_n", dir_n, 2);
        chk("t1_addr_seq", addr_code, 32'h012);
        chk("t1_addr_n", addr_n, 3);
        chk("t1_busy_at_done", busy1, 0);
        idle_chk("t1_after", 0);

        // 2: 50 entries of count 1, every Tick lands in a FETCH cycle
        clear_ram();
        for (int i = 0; i < 50; i++) ram1[i] = ent(FWD, 1);
        play(0, 50, 1, 3, -1, -1, 400);
        chk("t2_done_cyc", done_cyc, 153);
        chk("t2_ticks", issued, 50);
        chk("t2_addr_n", addr_n, 51);
        chk("t2_dir_seq", dir_code, FWD);
        idle_chk("t2_after", 0);

        // 3: zero-count entry with a direction is skipped
        clear_ram();
        ram1[0] = ent(RIGHT, 0); ram1[1] = ent(FWD, 1);
        play(0, 1, 5, 4, -1, -1, 100);
        chk("t3_done_cyc", done_cyc, 8);
        chk("t3_dir_seq", dir_code, FWD);
        chk("t3_dir_n", dir_n, 1);
        chk("t3_fwd_ticks", tally[FWD], 1);
        chk("t3_addr_seq", addr_code, 32'h012);
        idle_chk("t3_after", 0);

        // 4a: Abort together with Tick in PLAY (Remaining = 7)
        clear_ram();
        ram1[0] = ent(FWD, 7);
        play(0, 7, 3, 1, 3, -1, 100);
        chk("t4a_done_cyc", done_cyc, 4);
        chk("t4a_dir_at_done", direction1, FWD);
        idle_chk("t4a_after", 0);

        // 4b: Abort in FETCH
        play(0, 0, 0, 1, 1, -1, 100);
        chk("t4b_done_cyc", done_cyc, 2);
        chk("t4b_dir_n", dir_n, 0);
        idle_chk("t4b_after", 0);

        // 4c: Start and Abort together in IDLE -> Start wins, full entry plays
        play(0, 7, 3, 1, 0, -1, 100);
        chk("t4c_done_cyc", done_cyc, 12);
        chk("t4c_fwd_ticks", tally[FWD], 7);
        idle_chk("t4c_after", 0);

        // 5: 4-entry memory, all {Fwd,1}; ends after address 3 without wrapping
        for (int i = 0; i < 4; i++) ram2[i] = ent(FWD, 1);
        play(1, 4, 3, 3, -1, -1, 100);
        chk("t5_done_cyc", done_cyc, 13);
        chk("t5_addr_seq", addr_code, 32'h0123);
        chk("t5_addr_n", addr_n, 4);
        chk("t5_addr_at_done", mem_address2, 3);
        idle_chk("t5_after", 1);
        chk("t5_addr_idle", mem_address2, 3);

        // 6: Start while busy ignored; reset during PLAY of entry 5
        clear_ram();
        for (int i = 0; i < 10; i++) ram1[i] = ent(BACK, 1);
        play(0, 100, 3, 3, -1, 10, 18);
        chk("t6_no_done", done_cyc, -1);
        chk("t6_addr_entry5", mem_address1, 5);
        @(negedge clk);
        chk("t6_busy_play", busy1, 1);
        chk("t6_dir_play", direction1, BACK);
        rst  = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        tick = 1'b0;
        chk("t6_rst_busy", busy1, 0);
        chk("t6_rst_addr", mem_address1, 0);
        chk("t6_rst_dir", direction1, NONE);
        chk("t6_rst_done", done1, 0);
        @(negedge clk);
        chk("t6_rst_done2", done1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
